change_item_dispenser: RTL and testbench

- Downstream stage of the vending-machine FSM.
- Consumes the one-cycle vend result (done, item_name, item_amt, change) and drives the physical item motor and coin hopper, one unit per valid/ack handshake.
- Change is paid out greedily in quarters, then dimes, then nickels. Coin encoding matches the machine's coin input: 001 = 5c, 010 = 10c, 100 = 25c.
- Reports completion, overrun and fault status back to the front panel.

---
 rtl/change_item_dispenser.sv | 194 +++++++++++++++++++
 tb/tb_change_item_dispenser.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/change_item_dispenser.sv
// change_item_dispenser
//   Downstream stage of the vending machine. Captures a one-cycle vend result, then
//   dispenses item units and greedy change (quarters, dimes, nickels) one unit per
//   valid/ack handshake. Reports completion, overrun and fault status.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   done, item_name,
//   item_amt, change         vend result, valid while done is high
//   item_valid/item_ack      item motor handshake, item_id holds the latched code
//   coin_valid/coin_ack      coin hopper handshake, coin_sel one-hot (001=5c 010=10c 100=25c)
//   busy, fin                not idle / one-cycle completion pulse
//   paid_out                 cents ejected in the current or last transaction
//   fault, overrun           sticky status, cleared only by rst
module change_item_dispenser #(
  parameter int unsigned CHG_W   = 6,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [2:0]       item_name,
  input  logic [1:0]       item_amt,
  input  logic [CHG_W-1:0] change,
  input  logic             item_ack,
  input  logic             coin_ack,
  output logic             item_valid,
  output logic [2:0]       item_id,
  output logic             coin_valid,
  output logic [2:0]       coin_sel,
  output logic             busy,
  output logic             fin,
  output logic [CHG_W-1:0] paid_out,
  output logic             fault,
  output logic             overrun
);

  localparam logic [CHG_W-1:0] C5  = CHG_W'(5);
  localparam logic [CHG_W-1:0] C10 = CHG_W'(10);
  localparam logic [CHG_W-1:0] C25 = CHG_W'(25);
  localparam logic [7:0]       WaitMax = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StItem, StCoin, StFin} state_e;

  state_e           state_q;
  logic [1:0]       units_q;
  logic [CHG_W-1:0] remaining_q;
  logic [CHG_W-1:0] paid_q;
  logic [7:0]       wait_q;
  logic             item_valid_q, coin_valid_q, busy_q, fin_q, fault_q, overrun_q;
  logic [2:0]       item_id_q, coin_sel_q;

  logic [CHG_W-1:0] coin_val;
  logic [CHG_W-1:0] rem_after;
  logic             item_ok;
  logic             wait_expired;

  // Largest coin that still fits in the amount; 000 when below a nickel.
  function automatic logic [2:0] sel_for(input logic [CHG_W-1:0] v);
    if (v >= C25)      return 3'b100;
    else if (v >= C10) return 3'b010;
    else if (v >= C5)  return 3'b001;
    else               return 3'b000;
  endfunction

  always_comb begin
    coin_val = '0;
    unique case (coin_sel_q)
      3'b100:  coin_val = C25;
      3'b010:  coin_val = C10;
      3'b001:  coin_val = C5;
      default: coin_val = '0;
    endcase
    rem_after    = remaining_q - coin_val;
    item_ok      = (item_name >= 3'd1) && (item_name <= 3'd5);
    wait_expired = (wait_q == WaitMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      units_q      <= '0;
      remaining_q  <= '0;
      paid_q       <= '0;
      wait_q       <= '0;
      item_valid_q <= 1'b0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      fault_q      <= 1'b0;
      overrun_q    <= 1'b0;
      item_id_q    <= '0;
      coin_sel_q   <= '0;
    end else begin
      fin_q <= 1'b0;
      // A result arriving while busy (FIN included) is dropped.
      if (done && busy_q) overrun_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (done) begin
            item_id_q   <= item_name;
            units_q     <= item_amt;
            remaining_q <= change;
            paid_q      <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b1;
            if (item_amt != 2'd0 && item_ok) begin
              state_q      <= StItem;
              item_valid_q <= 1'b1;
            end else if (change != '0) begin
              state_q      <= StCoin;
              coin_sel_q   <= sel_for(change);
              coin_valid_q <= (change >= C5);
            end else begin
              state_q <= StFin;
              fin_q   <= 1'b1;
            end
          end
        end
        StItem: begin
          if (item_ack) begin
            wait_q <= '0;
            if (units_q == 2'd1) begin
              units_q      <= '0;
              item_valid_q <= 1'b0;
              if (remaining_q != '0) begin
                state_q      <= StCoin;
                coin_sel_q   <= sel_for(remaining_q);
                coin_valid_q <= (remaining_q >= C5);
              end else begin
                state_q <= StFin;
                fin_q   <= 1'b1;
              end
            end else begin
              units_q <= units_q - 2'd1;
            end
          end else if (wait_expired) begin
            item_valid_q <= 1'b0;
            fault_q      <= 1'b1;
            state_q      <= StFin;
            fin_q        <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StCoin: begin
          if (!coin_valid_q) begin
            // Entered with less than a nickel owed: nothing payable.
            coin_sel_q <= '0;
            fault_q    <= 1'b1;
            state_q    <= StFin;
            fin_q      <= 1'b1;
          end else if (coin_ack) begin
            wait_q      <= '0;
            remaining_q <= rem_after;
            paid_q      <= paid_q + coin_val;
            if (rem_after < C5) begin
              coin_valid_q <= 1'b0;
              coin_sel_q   <= '0;
              if (rem_after != '0) fault_q <= 1'b1;
              state_q <= StFin;
              fin_q   <= 1'b1;
            end else begin
              coin_sel_q <= sel_for(rem_after);
            end
          end else if (wait_expired) begin
            coin_valid_q <= 1'b0;
            coin_sel_q   <= '0;
            fault_q      <= 1'b1;
            state_q      <= StFin;
            fin_q        <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign item_valid = item_valid_q;
  assign item_id    = item_id_q;
  assign coin_valid = coin_valid_q;
  assign coin_sel   = coin_sel_q;
  assign busy       = busy_q;
  assign fin        = fin_q;
  assign paid_out   = paid_q;
  assign fault      = fault_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_change_item_dispenser.sv
module tb_change_item_dispenser;

  localparam int CW = 6;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst, done, item_ack, coin_ack;
  logic [2:0]    item_name;
  logic [1:0]    item_amt;
  logic [CW-1:0] change;
  logic          item_valid, coin_valid, busy, fin, fault, overrun;
  logic [2:0]    item_id, coin_sel;
  logic [CW-1:0] paid_out;

  int npass = 0;
  int ntot  = 0;
  bit exp_fault = 1'b0;
  bit exp_ovr   = 1'b0;

  change_item_dispenser #(.CHG_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .done(done), .item_name(item_name), .item_amt(item_amt),
    .change(change), .item_ack(item_ack), .coin_ack(coin_ack), .item_valid(item_valid),
    .item_id(item_id), .coin_valid(coin_valid), .coin_sel(coin_sel), .busy(busy),
    .fin(fin), .paid_out(paid_out), .fault(fault), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_item_valid"}, 32'(item_valid), 0);
    chk({tag, "_item_id"},    32'(item_id), 0);
    chk({tag, "_coin_valid"}, 32'(coin_valid), 0);
    chk({tag, "_coin_sel"},   32'(coin_sel), 0);
    chk({tag, "_busy"},       32'(busy), 0);
    chk({tag, "_fin"},        32'(fin), 0);
    chk({tag, "_paid_out"},   32'(paid_out), 0);
    chk({tag, "_fault"},      32'(fault), 0);
    chk({tag, "_overrun"},    32'(overrun), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; done = 1'b0; item_ack = 1'b0; coin_ack = 1'b0;
    step();
    chk_zero_outputs(tag);
    rst = 1'b0;
    exp_fault = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // Reference: greedy change from the rules, acks driven with random per-unit delays.
  task automatic run_txn(input logic [2:0] nm, input logic [1:0] amt, input logic [CW-1:0] chg,
                         input int dmin, input int dmax, input int ovr_k, input bit check_lat);
    int exp_items, r, items_seen, coins_seen, idly, cdly, fin_k, gap, order_err;
    int q[$];
    bit exp_f;
    exp_items = (nm >= 1 && nm <= 5) ? int'(amt) : 0;
    r = int'(chg);
    while (r >= 25) begin q.push_back(4); r -= 25; end
    while (r >= 10) begin q.push_back(2); r -= 10; end
    while (r >= 5)  begin q.push_back(1); r -= 5;  end
    exp_f = (r != 0);
    items_seen = 0; coins_seen = 0; gap = 0; order_err = 0; fin_k = -1;
    idly = $urandom_range(dmax, dmin);
    cdly = $urandom_range(dmax, dmin);

    item_name = nm; item_amt = amt; change = chg; done = 1'b1;
    step();
    done = 1'b0;
    chk("busy_after_capture", 32'(busy), 1);
    chk("item_id_latched", 32'(item_id), 32'(nm));

    for (int k = 1; k <= 300; k++) begin
      done = (k == ovr_k);
      if (done) begin
        item_name = 3'd1; item_amt = 2'd3; change = 6'd55;
        exp_ovr = 1'b1;
      end
      if (fin) begin fin_k = k; break; end
      if (items_seen < exp_items && item_valid !== 1'b1) gap++;
      if (coin_valid && items_seen < exp_items) order_err++;
      if (item_valid) begin
        if (idly == 0) begin
          item_ack = 1'b1; items_seen++; idly = $urandom_range(dmax, dmin);
        end else begin
          item_ack = 1'b0; idly--;
        end
      end else item_ack = 1'($urandom_range(1, 0));
      if (coin_valid) begin
        if (cdly == 0) begin
          coin_ack = 1'b1;
          if (coins_seen < q.size()) chk("coin_sel", 32'(coin_sel), 32'(q[coins_seen]));
          else chk("coin_count_excess", 32'(coins_seen + 1), 32'(q.size()));
          coins_seen++; cdly = $urandom_range(dmax, dmin);
        end else begin
          coin_ack = 1'b0; cdly--;
        end
      end else coin_ack = 1'($urandom_range(1, 0));
      step();
    end

    item_ack = 1'b0; coin_ack = 1'b0;
    if (exp_f) exp_fault = 1'b1;
    chk("fin_seen", 32'(fin_k > 0), 1);
    chk("paid_out", 32'(paid_out), 32'(chg) - 32'(r));
    chk("fault", 32'(fault), 32'(exp_fault));
    chk("busy_in_fin", 32'(busy), 1);
    chk("items_dispensed", 32'(items_seen), 32'(exp_items));
    chk("coins_dispensed", 32'(coins_seen), 32'(q.size()));
    chk("item_valid_held", 32'(gap), 0);
    chk("items_before_coins", 32'(order_err), 0);
    if (check_lat) chk("fin_latency", 32'(fin_k), 32'(1 + exp_items + q.size()));
    step();
    done = 1'b0;
    chk("fin_one_cycle", 32'(fin), 0);
    chk("busy_after_fin", 32'(busy), 0);
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    step();
    chk("idle_stays_idle", 32'(busy | item_valid | coin_valid), 0);
    chk("paid_out_holds", 32'(paid_out), 32'(chg) - 32'(r));
  endtask

  initial begin
    int cnt, seen_fin;
    rst = 1'b1; done = 1'b0; item_ack = 1'b0; coin_ack = 1'b0;
    item_name = '0; item_amt = '0; change = '0;
    step();
    do_reset("reset");

    // Item plus change, acks effectively tied high.
    run_txn(3'd2, 2'd1, 6'd40, 0, 0, 0, 1'b1);
    // Three units, each acked after 3 cycles.
    run_txn(3'd5, 2'd3, 6'd0, 3, 3, 0, 1'b0);
    // Residue of 3 after 25+25+10.
    run_txn(3'd1, 2'd0, 6'd63, 0, 0, 0, 1'b1);
    do_reset("reset_after_fault");

    // Timeout: hopper never acks.
    item_name = 3'd0; item_amt = 2'd0; change = 6'd10; done = 1'b1;
    step();
    done = 1'b0; coin_ack = 1'b0;
    cnt = 0; seen_fin = 0;
    for (int k = 0; k < 20; k++) begin
      if (fin) begin seen_fin = 1; break; end
      if (coin_valid) cnt++;
      step();
    end
    chk("timeout_valid_cycles", 32'(cnt), TO);
    chk("timeout_fin", 32'(seen_fin), 1);
    chk("timeout_fault", 32'(fault), 1);
    chk("timeout_paid_out", 32'(paid_out), 0);
    chk("timeout_valid_dropped", 32'(coin_valid), 0);
    do_reset("reset_after_timeout");

    // Overrun in the FIN cycle of an empty transaction, then mid-transaction.
    run_txn(3'd3, 2'd0, 6'd0, 0, 0, 1, 1'b1);
    run_txn(3'd2, 2'd2, 6'd35, 1, 2, 2, 1'b0);
    do_reset("reset_after_overrun");

    // Reset mid-COIN after the first quarter.
    item_name = 3'd7; item_amt = 2'd2; change = 6'd50; done = 1'b1;
    step();
    done = 1'b0;
    chk("invalid_item_no_motor", 32'(item_valid), 0);
    chk("first_coin_quarter", 32'(coin_sel), 4);
    coin_ack = 1'b1;
    step();
    chk("paid_after_quarter", 32'(paid_out), 25);
    rst = 1'b1; coin_ack = 1'b0;
    step();
    chk_zero_outputs("mid_coin_reset");
    rst = 1'b0;
    run_txn(3'd4, 2'd2, 6'd15, 0, 0, 0, 1'b1);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      run_txn(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)), 6'($urandom_range(63, 0)),
              0, 4, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
